// File: rtl/saleterminal_pkg.sv
// Shared sale-terminal definitions: keypad FSM states, command key codes, key map.
// No logic state; helpers are pure functions.
// No flow control of its own.
package saleterminal_pkg;

   typedef enum logic [2:0] {
      SCAN      = 3'd0,
      DEB_PRESS = 3'd1,
      EMIT      = 3'd2,
      WAIT_REL  = 3'd3,
      DEB_REL   = 3'd4
   } kp_state_t;

   typedef struct packed {
      logic [1:0] row;
      logic [3:0] pat;
   } key_hit_t;

   localparam logic [3:0] KEY_CMD_A    = 4'd10;
   localparam logic [3:0] KEY_CMD_B    = 4'd11;
   localparam logic [3:0] KEY_CMD_C    = 4'd12;
   localparam logic [3:0] KEY_CMD_D    = 4'd13;
   localparam logic [3:0] KEY_CMD_STAR = 4'd14;
   localparam logic [3:0] KEY_CMD_HASH = 4'd15;

   localparam logic [3:0] COLS_IDLE = 4'b1111;

   // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
   function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] code;
      case ({row, col})
         4'h0:    code = 4'd1;
         4'h1:    code = 4'd2;
         4'h2:    code = 4'd3;
         4'h3:    code = KEY_CMD_A;
         4'h4:    code = 4'd4;
         4'h5:    code = 4'd5;
         4'h6:    code = 4'd6;
         4'h7:    code = KEY_CMD_B;
         4'h8:    code = 4'd7;
         4'h9:    code = 4'd8;
         4'hA:    code = 4'd9;
         4'hB:    code = KEY_CMD_C;
         4'hC:    code = KEY_CMD_STAR;
         4'hD:    code = 4'd0;
         4'hE:    code = KEY_CMD_HASH;
         default: code = KEY_CMD_D;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] count_low(input logic [3:0] cols);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n = n + 3'(~cols[i]);
      end
      return n;
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] cols);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!cols[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs, resets to all-ones (idle pull-up level).
// Latency: 2 clocks.
// No backpressure; samples every clock.
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_digit_source.sv
// 4x4 keypad scanner with press/release debounce; one strobe per physical press.
// Latency: strobe DEBOUNCE_CYCLES+1 clocks after the first dwell sample that sees the key.
// No backpressure: consumer must take Digit_valid/Cmd_valid in the strobe cycle.
module keypad_digit_source
   import saleterminal_pkg::*;
#(
   parameter int SCAN_DIV        = 5000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] COL_N,
   output logic [3:0] ROW_N,
   output logic [3:0] Key_code,
   output logic       Digit_valid,
   output logic       Cmd_valid,
   output logic       Busy
);

   localparam int DW  = $clog2(SCAN_DIV);
   localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);

   kp_state_t      state;
   kp_state_t      state_nxt;
   logic [1:0]     row_idx;
   logic [DW-1:0]  dwell;
   logic [DBW-1:0] deb_cnt;
   key_hit_t       hit;
   logic [3:0]     cols;
   logic [2:0]     n_low;
   logic           sample;
   logic           deb_done;
   logic           cols_idle;
   logic [3:0]     emit_code;

   sync_2ff #(.WIDTH(4)) u_col_sync (
      .clk   (CLK),
      .rst_n (RESET_N),
      .d     (COL_N),
      .q     (cols)
   );

   assign n_low     = count_low(cols);
   assign sample    = (dwell == DWELL_LAST);
   assign deb_done  = (deb_cnt == DEB_LAST);
   assign cols_idle = (cols == COLS_IDLE);
   assign emit_code = keymap(hit.row, low_index(hit.pat));

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= SCAN;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         SCAN: begin
            if (sample) begin
               if (n_low == 3'd1)      state_nxt = DEB_PRESS;
               else if (n_low != 3'd0) state_nxt = WAIT_REL;
            end
         end
         DEB_PRESS: begin
            if (cols != hit.pat) state_nxt = SCAN;
            else if (deb_done)   state_nxt = EMIT;
         end
         EMIT:     state_nxt = WAIT_REL;
         WAIT_REL: begin
            if (cols_idle) state_nxt = DEB_REL;
         end
         DEB_REL: begin
            if (!cols_idle)    state_nxt = WAIT_REL;
            else if (deb_done) state_nxt = SCAN;
         end
         default:  state_nxt = SCAN;
      endcase
   end

   always_comb begin
      ROW_N = ~(4'b0001 << row_idx);
      Busy  = (state != SCAN);
   end

   // Row index only moves on an idle sample or after a completed release; a key keeps its row held.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         row_idx     <= 2'd0;
         dwell       <= '0;
         deb_cnt     <= '0;
         hit         <= '{row: 2'd0, pat: COLS_IDLE};
         Key_code    <= 4'd0;
         Digit_valid <= 1'b0;
         Cmd_valid   <= 1'b0;
      end else begin
         Digit_valid <= 1'b0;
         Cmd_valid   <= 1'b0;
         case (state)
            SCAN: begin
               if (sample) begin
                  dwell <= '0;
                  if (n_low == 3'd1) begin
                     hit     <= '{row: row_idx, pat: cols};
                     deb_cnt <= '0;
                  end else if (n_low == 3'd0) begin
                     row_idx <= row_idx + 2'd1;
                  end
               end else begin
                  dwell <= dwell + DW'(1);
               end
            end
            DEB_PRESS: begin
               if (cols != hit.pat) dwell   <= '0;
               else if (!deb_done)  deb_cnt <= deb_cnt + DBW'(1);
            end
            EMIT: begin
               Key_code    <= emit_code;
               Digit_valid <= (emit_code < KEY_CMD_A);
               Cmd_valid   <= (emit_code >= KEY_CMD_A);
            end
            WAIT_REL: begin
               if (cols_idle) deb_cnt <= '0;
            end
            DEB_REL: begin
               if (cols_idle) begin
                  if (deb_done) begin
                     row_idx <= row_idx + 2'd1;
                     dwell   <= '0;
                  end else begin
                     deb_cnt <= deb_cnt + DBW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   a_strobe_excl: assert property (@(posedge CLK) disable iff (!RESET_N)
      !(Digit_valid && Cmd_valid));
   a_strobe_single: assert property (@(posedge CLK) disable iff (!RESET_N)
      (Digit_valid || Cmd_valid) |=> !(Digit_valid || Cmd_valid));

endmodule

// File: tb/tb_keypad_digit_source.sv
// Randomized keypad bench: a key-matrix model drives COL_N, strobes are scored against a press-level model.
module tb_keypad_digit_source;

   localparam int SCAN_DIV = 8;
   localparam int DEB      = 16;
   localparam int REL_CYC  = 2 + 1 + DEB;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [3:0] COL_N;
   logic [3:0] ROW_N;
   logic [3:0] Key_code;
   logic       Digit_valid;
   logic       Cmd_valid;
   logic       Busy;

   logic [15:0] pressed = '0;
   int n_checks = 0;
   int n_errors = 0;

   int key_val [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   int exp_code[$];
   int exp_cmd[$];
   int obs_code[$];
   int obs_cmd[$];
   int obs_lat[$];
   int busy_age = 0;
   int rule_viol = 0;
   logic busy_q = 1'b0;
   logic strobe_q = 1'b0;

   always #5 CLK = ~CLK;

   keypad_digit_source #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYCLES(DEB)) dut (
      .CLK         (CLK),
      .RESET_N     (RESET_N),
      .COL_N       (COL_N),
      .ROW_N       (ROW_N),
      .Key_code    (Key_code),
      .Digit_valid (Digit_valid),
      .Cmd_valid   (Cmd_valid),
      .Busy        (Busy)
   );

   // Closed key shorts its column to its row whenever that row is driven low.
   always_comb begin
      COL_N = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !ROW_N[r]) COL_N[c] = 1'b0;
   end

   always @(negedge CLK) begin
      if (Digit_valid && Cmd_valid) rule_viol++;
      if ((Digit_valid || Cmd_valid) && strobe_q) rule_viol++;
      if (Busy && !busy_q) busy_age = 0;
      else if (Busy) busy_age++;
      if (Digit_valid || Cmd_valid) begin
         obs_code.push_back(int'(Key_code));
         obs_cmd.push_back(int'(Cmd_valid));
         obs_lat.push_back(busy_age);
      end
      busy_q   = Busy;
      strobe_q = Digit_valid || Cmd_valid;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic wait_idle(input string tag, output int cycles);
      cycles = 0;
      while (Busy && cycles < 200) begin
         @(negedge CLK);
         cycles++;
      end
      check({tag, " idle timeout"}, int'(cycles < 200), 1);
   endtask

   task automatic compare_strobes(input string tag);
      check({tag, " strobe count"}, obs_code.size(), exp_code.size());
      for (int i = 0; i < exp_code.size() && i < obs_code.size(); i++) begin
         check({tag, " code"}, obs_code[i], exp_code[i]);
         check({tag, " kind"}, obs_cmd[i], exp_cmd[i]);
         check({tag, " latency"}, obs_lat[i], DEB + 1);
      end
      obs_code.delete();
      obs_cmd.delete();
      obs_lat.delete();
      exp_code.delete();
      exp_cmd.delete();
   endtask

   // Key already held long enough to be accepted; release and verify the return to scanning.
   task automatic press_single(input int k, input int hold, input string tag);
      int cyc;
      pressed[k] = 1'b1;
      wait_clks(hold);
      check({tag, " busy held"}, int'(Busy), 1);
      pressed = '0;
      exp_code.push_back(key_val[k]);
      exp_cmd.push_back(int'(key_val[k] >= 10));
      wait_idle(tag, cyc);
      check({tag, " release time"}, cyc, REL_CYC);
      check({tag, " next row"}, int'(ROW_N), 15 - (1 << ((k / 4 + 1) % 4)));
      check({tag, " code held"}, int'(Key_code), key_val[k]);
   endtask

   task automatic press_multi(input int r, input int c1, input int c2, input string tag);
      int cyc;
      pressed[r*4+c1] = 1'b1;
      pressed[r*4+c2] = 1'b1;
      wait_clks($urandom_range(60, 120));
      check({tag, " busy held"}, int'(Busy), 1);
      pressed = '0;
      wait_idle(tag, cyc);
      check({tag, " release time"}, cyc, REL_CYC);
      check({tag, " next row"}, int'(ROW_N), 15 - (1 << ((r + 1) % 4)));
   endtask

   initial begin
      int cyc;
      int k;
      int r;
      int c1;
      int obs_bar;
      int exp_bar;
      int seq [4] = '{4, 2, 1, 0};

      // reset state
      #2;
      check("rst row", int'(ROW_N), 14);
      check("rst key", int'(Key_code), 0);
      check("rst digit", int'(Digit_valid), 0);
      check("rst cmd", int'(Cmd_valid), 0);
      check("rst busy", int'(Busy), 0);
      wait_clks(3);
      RESET_N = 1'b1;

      // idle scan
      check("scan row n0", int'(ROW_N), 14);
      for (int n = 1; n <= 64; n++) begin
         @(negedge CLK);
         check("scan row", int'(ROW_N), 15 - (1 << ((n / SCAN_DIV) % 4)));
         check("scan busy", int'(Busy), 0);
      end
      compare_strobes("idle");

      press_single(5, 200, "key5");
      wait_clks(40);
      compare_strobes("key5");

      // bouncing '7'
      for (int i = 0; i < 6; i++) begin
         pressed[8] = (i % 2 == 0);
         wait_clks(5);
      end
      check("bounce quiet", obs_code.size(), 0);
      press_single(8, 80, "key7");
      wait_clks(10);
      compare_strobes("key7");

      press_single(14, 80, "hash");
      wait_clks(10);
      compare_strobes("hash");

      press_multi(0, 0, 1, "multi12");
      wait_clks(10);
      compare_strobes("multi12");

      // reset during press debounce of '9'
      pressed[10] = 1'b1;
      cyc = 0;
      while (!Busy && cyc < 100) begin
         @(negedge CLK);
         cyc++;
      end
      check("key9 busy", int'(Busy), 1);
      wait_clks(4);
      #1 RESET_N = 1'b0;
      #1;
      check("key9 rst row", int'(ROW_N), 14);
      check("key9 rst busy", int'(Busy), 0);
      check("key9 rst digit", int'(Digit_valid), 0);
      pressed = '0;
      wait_clks(3);
      RESET_N = 1'b1;
      wait_clks(40);
      compare_strobes("key9 abort");

      // 4,3,2,1 into the barcode path
      exp_bar = 0;
      for (int i = 0; i < 4; i++) begin
         exp_bar = exp_bar * 10 + key_val[seq[i]];
         press_single(seq[i], 80, "seq");
         wait_clks($urandom_range(3, 20));
      end
      obs_bar = 0;
      for (int i = 0; i < obs_code.size(); i++)
         if (obs_cmd[i] == 0) obs_bar = obs_bar * 10 + obs_code[i];
      check("barcode", obs_bar, exp_bar);
      compare_strobes("seq");

      // random single keys and same-row key pairs
      for (int i = 0; i < 10; i++) begin
         k = $urandom_range(0, 15);
         press_single(k, $urandom_range(60, 150), "rand key");
         wait_clks($urandom_range(3, 30));
      end
      compare_strobes("rand key");
      for (int i = 0; i < 3; i++) begin
         r  = $urandom_range(0, 3);
         c1 = $urandom_range(0, 3);
         press_multi(r, c1, (c1 + $urandom_range(1, 3)) % 4, "rand multi");
         wait_clks($urandom_range(3, 30));
      end
      compare_strobes("rand multi");

      check("strobe rules", rule_viol, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
